// File: rtl/bus_pack_v1_0.sv
// bus_pack_v1_0 -- narrow-to-wide lane packer with partial-word flush.
//
// Accepts in_width-bit lanes and packs them LSB-first into words of
// ratio lanes. A full word, or a partial word requested by flush, moves
// into an output holding register that is presented with valid/ready
// handshaking. The accumulator keeps filling while the output is held,
// and stalls only when the lane that would complete the next word arrives.
//
// Ports
//   clock      rising-edge clock for all state
//   reset_n    asynchronous active-low reset
//   in_data    narrow input lane (in_width bits)
//   in_valid   in_data valid this cycle
//   in_ready   lane accepted when in_valid && in_ready
//   flush      single-cycle request to emit a partially filled word
//   out_data   packed word; lane k at [(k+1)*in_width-1 : k*in_width]
//   out_lanes  number of valid lanes in out_data (1..ratio)
//   out_valid  out_data / out_lanes valid
//   out_ready  consumer takes the word when out_valid && out_ready
module bus_pack_v1_0 #(
   parameter int in_width = 8,
   parameter int ratio    = 4
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic [in_width-1:0]          in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         flush,
   output logic [in_width*ratio-1:0]    out_data,
   output logic [3:0]                   out_lanes,
   output logic                         out_valid,
   input  logic                         out_ready
);

   localparam int out_width = in_width * ratio;
   localparam int cnt_w     = $clog2(ratio);
   localparam logic [cnt_w-1:0] last_lane = cnt_w'(ratio - 1);

   logic [out_width-1:0] acc;
   logic [cnt_w-1:0]     cnt;

   logic                 blocked;
   logic                 accept;
   logic                 full_word;
   logic                 flush_go;
   logic                 load;
   logic [out_width-1:0] word_next;
   logic [3:0]           lanes_next;

   // Only the completing lane has to wait for the output register; lanes
   // 0..ratio-2 of the next word can still be buffered while it is held.
   assign blocked   = out_valid && !out_ready;
   assign in_ready  = !((cnt == last_lane) && blocked);
   assign accept    = in_valid && in_ready;
   assign full_word = accept && (cnt == last_lane);

   // A flush that lands on the completing lane is just the full word.
   // When blocked, the flush is dropped and the caller re-asserts it.
   assign flush_go  = flush && !full_word && !blocked && ((cnt != '0) || accept);
   assign load      = full_word || flush_go;

   // Accumulator contents with this cycle's lane (if any) merged in; the
   // upper lanes are already zero because the accumulator clears on load.
   always_comb begin
      word_next = acc;
      for (int k = 0; k < ratio; k++) begin
         if (accept && (cnt == cnt_w'(k))) begin
            word_next[k*in_width +: in_width] = in_data;
         end
      end
   end

   assign lanes_next = 4'(cnt) + 4'(accept);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (load) begin
         acc <= '0;
         cnt <= '0;
      end else if (accept) begin
         acc <= word_next;
         cnt <= cnt + 1'b1;
      end
   end

   // load never happens while blocked, so a held word stays stable.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_data  <= '0;
         out_lanes <= '0;
         out_valid <= 1'b0;
      end else if (load) begin
         out_data  <= word_next;
         out_lanes <= lanes_next;
         out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bus_pack_v1_0.sv
module tb_bus_pack_v1_0;

   logic        clock;
   logic        reset_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        flush;
   logic [31:0] out_data;
   logic [3:0]  out_lanes;
   logic        out_valid;
   logic        out_ready;

   int checks   = 0;
   int failures = 0;

   bus_pack_v1_0 #(.in_width(8), .ratio(4)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .out_data  (out_data),
      .out_lanes (out_lanes),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        f;
      logic        r;
      logic        e_ir;
      logic        e_ov;
      logic [31:0] e_od;
      logic [3:0]  e_ol;
      logic        push;
      logic [31:0] p_data;
      logic [3:0]  p_lanes;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  lanes;
   } word_t;

   vec_t  vecs[$];
   word_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [7:0] d, input logic f, input logic r,
                      input logic e_ir, input logic e_ov, input logic [31:0] e_od,
                      input logic [3:0] e_ol, input logic push = 1'b0,
                      input logic [31:0] p_data = '0, input logic [3:0] p_lanes = '0);
      vec_t t;
      t.v = v; t.d = d; t.f = f; t.r = r;
      t.e_ir = e_ir; t.e_ov = e_ov; t.e_od = e_od; t.e_ol = e_ol;
      t.push = push; t.p_data = p_data; t.p_lanes = p_lanes;
      vecs.push_back(t);
   endtask

   // One cycle: drive after the edge, check mid-cycle before the next edge.
   task automatic run_vec(input vec_t t, input int idx);
      word_t w;
      @(posedge clock);
      #1;
      in_valid  = t.v;
      in_data   = t.d;
      flush     = t.f;
      out_ready = t.r;
      if (t.push) begin
         w.data  = t.p_data;
         w.lanes = t.p_lanes;
         sb.push_back(w);
      end
      @(negedge clock);
      chk($sformatf("v%0d in_ready", idx),  {31'b0, in_ready},  {31'b0, t.e_ir});
      chk($sformatf("v%0d out_valid", idx), {31'b0, out_valid}, {31'b0, t.e_ov});
      chk($sformatf("v%0d out_data", idx),  out_data,           t.e_od);
      chk($sformatf("v%0d out_lanes", idx), {28'b0, out_lanes}, {28'b0, t.e_ol});
   endtask

   // Scoreboard: each handshake consumes the oldest expected word.
   always @(negedge clock) begin
      if (reset_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: got word %h lanes %0d expected none", out_data, out_lanes);
         end else begin
            word_t w;
            w = sb.pop_front();
            chk("sb_data", out_data, w.data);
            chk("sb_lanes", {28'b0, out_lanes}, {28'b0, w.lanes});
         end
      end
   end

   initial begin
      vec_t t;
      int   n;
      reset_n   = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;

      // Continuous fill
      add(1,8'h11,0,1, 1,0,32'h0,4'd0);
      add(1,8'h22,0,1, 1,0,32'h0,4'd0);
      add(1,8'h33,0,1, 1,0,32'h0,4'd0);
      add(1,8'h44,0,1, 1,0,32'h0,4'd0, 1,32'h44332211,4'd4);
      add(0,8'h00,0,1, 1,1,32'h44332211,4'd4);
      add(0,8'h00,0,1, 1,0,32'h44332211,4'd4);
      // Backpressure: accumulate into the next word, stall the completing lane
      add(1,8'h01,0,0, 1,0,32'h44332211,4'd4);
      add(1,8'h02,0,0, 1,0,32'h44332211,4'd4);
      add(1,8'h03,0,0, 1,0,32'h44332211,4'd4);
      add(1,8'h04,0,0, 1,0,32'h44332211,4'd4, 1,32'h04030201,4'd4);
      add(1,8'h05,0,0, 1,1,32'h04030201,4'd4);
      add(1,8'h06,0,0, 1,1,32'h04030201,4'd4);
      add(1,8'h07,0,0, 1,1,32'h04030201,4'd4);
      add(1,8'h08,0,0, 0,1,32'h04030201,4'd4);
      add(1,8'h08,0,0, 0,1,32'h04030201,4'd4);
      add(1,8'h08,0,1, 1,1,32'h04030201,4'd4, 1,32'h08070605,4'd4);
      add(0,8'h00,0,1, 1,1,32'h08070605,4'd4);
      add(0,8'h00,0,1, 1,0,32'h08070605,4'd4);
      // Partial flush, next lane lands in lane 0
      add(1,8'hAA,0,1, 1,0,32'h08070605,4'd4);
      add(1,8'hBB,0,1, 1,0,32'h08070605,4'd4);
      add(0,8'h00,1,1, 1,0,32'h08070605,4'd4, 1,32'h0000BBAA,4'd2);
      add(1,8'h55,0,1, 1,1,32'h0000BBAA,4'd2);
      add(1,8'h66,0,1, 1,0,32'h0000BBAA,4'd2);
      add(1,8'h77,0,1, 1,0,32'h0000BBAA,4'd2);
      add(1,8'h88,0,1, 1,0,32'h0000BBAA,4'd2, 1,32'h88776655,4'd4);
      add(0,8'h00,0,1, 1,1,32'h88776655,4'd4);
      add(0,8'h00,0,1, 1,0,32'h88776655,4'd4);
      // Flush with concurrent lane; flush at cnt 0 ignored
      add(1,8'hAA,0,1, 1,0,32'h88776655,4'd4);
      add(1,8'hCC,1,1, 1,0,32'h88776655,4'd4, 1,32'h0000CCAA,4'd2);
      add(0,8'h00,0,1, 1,1,32'h0000CCAA,4'd2);
      add(0,8'h00,1,1, 1,0,32'h0000CCAA,4'd2);
      add(0,8'h00,0,1, 1,0,32'h0000CCAA,4'd2);
      // Flush while blocked is dropped, later flush emits 2 lanes
      add(1,8'hA1,0,0, 1,0,32'h0000CCAA,4'd2);
      add(1,8'hA2,0,0, 1,0,32'h0000CCAA,4'd2);
      add(1,8'hA3,0,0, 1,0,32'h0000CCAA,4'd2);
      add(1,8'hA4,0,0, 1,0,32'h0000CCAA,4'd2, 1,32'hA4A3A2A1,4'd4);
      add(1,8'hB1,0,0, 1,1,32'hA4A3A2A1,4'd4);
      add(1,8'hB2,0,0, 1,1,32'hA4A3A2A1,4'd4);
      add(0,8'h00,1,0, 1,1,32'hA4A3A2A1,4'd4);
      add(0,8'h00,0,0, 1,1,32'hA4A3A2A1,4'd4);
      add(0,8'h00,0,1, 1,1,32'hA4A3A2A1,4'd4);
      add(0,8'h00,1,1, 1,0,32'hA4A3A2A1,4'd4, 1,32'h0000B2B1,4'd2);
      add(0,8'h00,0,1, 1,1,32'h0000B2B1,4'd2);
      add(0,8'h00,0,1, 1,0,32'h0000B2B1,4'd2);
      // Flush coincident with the completing lane: one full word only
      add(1,8'hC1,0,1, 1,0,32'h0000B2B1,4'd2);
      add(1,8'hC2,0,1, 1,0,32'h0000B2B1,4'd2);
      add(1,8'hC3,0,1, 1,0,32'h0000B2B1,4'd2);
      add(1,8'hC4,1,1, 1,0,32'h0000B2B1,4'd2, 1,32'hC4C3C2C1,4'd4);
      add(0,8'h00,0,1, 1,1,32'hC4C3C2C1,4'd4);
      add(0,8'h00,0,1, 1,0,32'hC4C3C2C1,4'd4);

      // Reset state, including in_ready high while held in reset
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst in_ready",  {31'b0, in_ready},  32'd1);
      chk("rst out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst out_data",  out_data,           32'h0);
      chk("rst out_lanes", {28'b0, out_lanes}, 32'd0);
      #2 reset_n = 1'b1;

      n = 0;
      foreach (vecs[i]) begin
         run_vec(vecs[i], n);
         n++;
      end

      // Reset mid-word with a held output word and 3 buffered lanes
      vecs.delete();
      add(1,8'hE1,0,0, 1,0,32'hC4C3C2C1,4'd4);
      add(1,8'hE2,0,0, 1,0,32'hC4C3C2C1,4'd4);
      add(1,8'hE3,0,0, 1,0,32'hC4C3C2C1,4'd4);
      add(1,8'hE4,0,0, 1,0,32'hC4C3C2C1,4'd4);
      add(1,8'hD1,0,0, 1,1,32'hE4E3E2E1,4'd4);
      add(1,8'hD2,0,0, 1,1,32'hE4E3E2E1,4'd4);
      add(1,8'hD3,0,0, 1,1,32'hE4E3E2E1,4'd4);
      foreach (vecs[i]) begin
         run_vec(vecs[i], n);
         n++;
      end
      @(posedge clock);
      #1 in_valid = 1'b0;
      @(negedge clock);
      chk("pre_rst in_ready", {31'b0, in_ready}, 32'd0);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst out_valid", {31'b0, out_valid}, 32'd0);
      chk("mid_rst out_data",  out_data,           32'h0);
      chk("mid_rst out_lanes", {28'b0, out_lanes}, 32'd0);
      chk("mid_rst in_ready",  {31'b0, in_ready},  32'd1);
      #1 reset_n = 1'b1;

      vecs.delete();
      add(1,8'hF1,0,1, 1,0,32'h0,4'd0);
      add(1,8'hF2,0,1, 1,0,32'h0,4'd0);
      add(1,8'hF3,0,1, 1,0,32'h0,4'd0);
      add(1,8'hF4,0,1, 1,0,32'h0,4'd0, 1,32'hF4F3F2F1,4'd4);
      add(0,8'h00,0,1, 1,1,32'hF4F3F2F1,4'd4);
      add(0,8'h00,0,1, 1,0,32'hF4F3F2F1,4'd4);
      foreach (vecs[i]) begin
         run_vec(vecs[i], n);
         n++;
      end

      @(posedge clock);
      @(negedge clock);
      chk("sb_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus_pack_v1_0.md
BUS_PACK_V1_0 -- requirements
Module: bus_pack_v1_0

Interface
REQ-001 The block SHALL have parameter in_width, default 8, giving the narrow input lane width in bits (1..32).
REQ-002 The block SHALL have parameter ratio, default 4, giving the number of input lanes per output word (2..8).
REQ-003 The block SHALL define out_width = in_width*ratio as a derived value; it SHALL NOT be independently settable.
REQ-004 The block SHALL have a single clock; reset is asynchronous and active-low.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 in_data  input  in_width  narrow input lane.
REQ-008 in_valid  input  1  in_data is valid this cycle.
REQ-009 in_ready  output  1  block accepts in_data this cycle; transfer when in_valid && in_ready.
REQ-010 flush  input  1  single-cycle request to emit a partially filled word.
REQ-011 out_data  output  out_width  packed word; lane k occupies bits [(k+1)*in_width-1 : k*in_width].
REQ-012 out_lanes  output  4  number of valid lanes in out_data (1..ratio).
REQ-013 out_valid  output  1  out_data and out_lanes are valid.
REQ-014 out_ready  input  1  consumer takes the word; transfer when out_valid && out_ready.

Function
REQ-015 The block SHALL keep an accumulator register (out_width bits) and a lane counter cnt (0..ratio-1), plus an output holding register with its own valid flag.
REQ-016 Accepted lanes SHALL be written LSB-first: the first lane after an emitted word goes to lane 0, the next to lane 1, and so on.
REQ-017 Define blocked = out_valid && !out_ready; in_ready SHALL equal !(cnt == ratio-1 && blocked).
REQ-018 An accepted lane with cnt == ratio-1 SHALL complete the word: the full word moves to the output register at that edge, with out_lanes = ratio and out_valid = 1; cnt SHALL return to 0 and the accumulator SHALL clear to 0.
REQ-019 Latency SHALL be one edge: a word completed at edge N is visible on out_data with out_valid = 1 in the cycle after edge N.
REQ-020 An accepted lane with cnt < ratio-1 and no flush SHALL only update the accumulator and increment cnt; the output register SHALL be unaffected.
REQ-021 When flush = 1 and cnt > 0 (or a lane is accepted in the same cycle), the block SHALL emit a partial word:
- lanes = cnt (+1 if a lane is accepted that cycle);
- unused upper lanes zero;
- cnt and accumulator cleared.
REQ-022 When flush = 1, cnt = 0 and no lane is accepted, flush SHALL be ignored and no word is emitted.
REQ-023 A partial flush SHALL be accepted only when !blocked; if blocked, the flush SHALL be dropped and the accumulator kept intact (the caller re-asserts it).
REQ-024 A flush coincident with an accepted lane that completes a full word SHALL emit one full word (out_lanes = ratio) and SHALL NOT emit an extra empty word.
REQ-025 While blocked, out_data and out_lanes SHALL hold stable.
REQ-026 out_valid SHALL clear on an out_ready transfer unless a new word is loaded at the same edge, in which case out_valid stays 1 and the new word appears with no bubble.
REQ-027 The block SHALL sustain one accepted lane per cycle indefinitely while out_ready = 1.
REQ-028 Input acceptance SHALL continue into lanes 0..ratio-2 of the next word while the output is blocked.

Reset
REQ-029 On reset_n low, asynchronously and regardless of clock:
- cnt = 0;
- accumulator = 0;
- out_data = 0;
- out_lanes = 0;
- out_valid = 0.
REQ-030 While reset_n is low, in_ready SHALL be 1 per REQ-017, but no transfer SHALL occur.
REQ-031 A reset asserted mid-word SHALL discard all buffered lanes and any held output word; the first accepted lane after release goes to lane 0.

Verification
REQ-032 The bench SHALL cover the following directed scenarios (in_width = 8, ratio = 4):
- Continuous fill: in_valid = 1, lanes 0x11, 0x22, 0x33, 0x44 on consecutive cycles, out_ready = 1 -> one cycle after the 4th lane: out_data = 0x44332211, out_lanes = 4, out_valid = 1 for exactly one cycle.
- Backpressure: out_ready = 0, stream 8 lanes 0x01..0x08 -> first word 0x04030201 held; lanes 0x05..0x07 accepted; in_ready = 0 while 0x08 waits. Raising out_ready -> 0x04030201 then 0x08070605 delivered back-to-back, no gap.
- Partial flush: lanes 0xAA, 0xBB, then flush = 1 -> out_data = 0x0000BBAA, out_lanes = 2; the next lane lands in lane 0.
- Flush with concurrent lane: cnt = 1 (0xAA held), flush with lane 0xCC -> out_data = 0x0000CCAA, out_lanes = 2. Flush at cnt = 0 with no lane -> no output.
- Flush while blocked: out_valid = 1, out_ready = 0, cnt = 2, flush -> no change, cnt stays 2; a later flush with out_ready = 1 -> 2-lane word emitted.
- Reset mid-word: cnt = 3, reset_n pulsed low between edges -> outputs zero immediately; after release, 4 new lanes produce a correct word with no residue.
